// File: rtl/tuart_tx_frame.sv
// UART transmitter that serialises the selected words of a latched command buffer.
// Words go out in ascending index order; XON/XOFF pauses the stream only between words.
module tuart_tx_frame #(
  parameter int WORD_BITS      = 8,
  parameter int CMD_WORDS      = 4,
  parameter int CLK_PER_SAMPLE = 5,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int LSB_FIRST      = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           stb_i,
  output logic                           rdy_o,
  input  logic [CMD_WORDS*WORD_BITS-1:0] data_i,
  input  logic [CMD_WORDS-1:0]           sel_i,
  input  logic                           xstb_i,
  input  logic                           xoff_i,
  input  logic                           xon_i,
  output logic                           tx_o
);

  localparam int CNT_W  = $clog2(CLK_PER_SAMPLE);
  localparam int BIT_W  = $clog2(WORD_BITS);
  localparam int WIDX_W = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PAUSE
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [BIT_W-1:0]               bit_q, bit_d;
  logic                           stop_q, stop_d;
  logic                           paused_q, paused_d;
  logic [CMD_WORDS*WORD_BITS-1:0] data_q, data_d;
  logic [CMD_WORDS-1:0]           sel_q, sel_d;

  logic [WORD_BITS-1:0] words [CMD_WORDS];
  logic [CMD_WORDS-1:0] cur_onehot;
  logic [CMD_WORDS-1:0] rest_sel;
  logic [WIDX_W-1:0]    widx;
  logic [WORD_BITS-1:0] cur_word;
  logic [BIT_W-1:0]     bit_sel;
  logic                 data_bit;
  logic                 par_bit;
  logic                 cnt_done;
  logic                 bit_last;
  logic                 stop_last;
  logic                 accept;
  logic                 timed_state;
  logic                 word_end;

  genvar gi;
  generate
    for (gi = 0; gi < CMD_WORDS; gi++) begin : g_words
      assign words[gi] = data_q[gi*WORD_BITS +: WORD_BITS];
    end
  endgenerate

  // sel_q holds the words still to send; the lowest set bit is the word on the line.
  assign cur_onehot = sel_q & (~sel_q + CMD_WORDS'(1));
  assign rest_sel   = sel_q & ~cur_onehot;

  always_comb begin
    widx = '0;
    for (int i = CMD_WORDS - 1; i >= 0; i--) begin
      if (sel_q[i]) widx = WIDX_W'(i);
    end
  end

  assign cur_word    = words[widx];
  assign bit_sel     = (LSB_FIRST != 0) ? bit_q : (BIT_W'(WORD_BITS - 1) - bit_q);
  assign data_bit    = cur_word[bit_sel];
  assign par_bit     = (PARITY == 1) ? ~^cur_word : ^cur_word;
  assign cnt_done    = (cnt_q == CNT_W'(CLK_PER_SAMPLE - 1));
  assign bit_last    = (bit_q == BIT_W'(WORD_BITS - 1));
  assign stop_last   = (STOP_BITS == 1) || stop_q;
  assign accept      = (state_q == S_IDLE) && stb_i && (|sel_i);
  assign timed_state = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
  assign word_end    = (state_q == S_STOP) && cnt_done && stop_last;

  // Flag updates are visible to the same-cycle word-boundary decision.
  always_comb begin
    paused_d = paused_q;
    if (xstb_i && xoff_i && !xon_i) begin
      paused_d = 1'b1;
    end else if (xstb_i && xon_i && !xoff_i) begin
      paused_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      paused_q <= 1'b0;
      data_q   <= '0;
      sel_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      paused_q <= paused_d;
      data_q   <= data_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = paused_d ? S_PAUSE : S_START;
      end
      S_START: begin
        if (cnt_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_done && bit_last) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (cnt_done) state_d = S_STOP;
      end
      S_STOP: begin
        if (word_end) begin
          if (rest_sel == '0) begin
            state_d = S_IDLE;
          end else if (paused_d) begin
            state_d = S_PAUSE;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_PAUSE: begin
        if (!paused_d) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    bit_d  = '0;
    stop_d = 1'b0;
    data_d = data_q;
    sel_d  = sel_q;
    if (timed_state && !cnt_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (state_q == S_DATA) begin
      bit_d = bit_q;
      if (cnt_done) bit_d = bit_last ? '0 : (bit_q + BIT_W'(1));
    end
    if (state_q == S_STOP) begin
      stop_d = stop_q;
      if (cnt_done) stop_d = !stop_last;
    end
    if (accept) begin
      data_d = data_i;
      sel_d  = sel_i;
    end
    if (word_end) begin
      sel_d = rest_sel;
    end
  end

  always_comb begin
    tx_o  = 1'b1;
    rdy_o = 1'b0;
    case (state_q)
      S_IDLE:   rdy_o = 1'b1;
      S_START:  tx_o  = 1'b0;
      S_DATA:   tx_o  = data_bit;
      S_PARITY: tx_o  = par_bit;
      default:  tx_o  = 1'b1;
    endcase
  end

endmodule
